// File: rtl/tmds_rx_pkg.sv
// Shared definitions for the TMDS receive channel: FSM state encoding,
// control-token words and the 10b->8b decode helpers.
package tmds_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    WAIT   = 2'd2,
    LOCKED = 2'd3
  } rx_state_e;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  function automatic logic is_ctrl_token(input logic [9:0] word);
    return (word == TOKEN_C00) || (word == TOKEN_C01) ||
           (word == TOKEN_C10) || (word == TOKEN_C11);
  endfunction

  function automatic logic [1:0] ctrl_token_value(input logic [9:0] word);
    logic [1:0] c;
    case (word)
      TOKEN_C01: c = 2'b01;
      TOKEN_C10: c = 2'b10;
      TOKEN_C11: c = 2'b11;
      default:   c = 2'b00;
    endcase
    return c;
  endfunction

  // word[9] undoes the DC-balance inversion, word[8] selects XOR vs XNOR chaining.
  function automatic logic [7:0] tmds_decode_word(input logic [9:0] word);
    logic [7:0] d;
    logic [7:0] q;
    d    = word[9] ? ~word[7:0] : word[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

endpackage

// File: rtl/tmds_rx_align_fsm.sv
// Word-alignment FSM for one TMDS channel: searches for control-token runs,
// pulses bitslip when a search window expires, and tracks loss of lock.
// Optional TMDS_RX_SLIP_COUNT_EN adds saturating slip/loss counters.
module tmds_rx_align_fsm
  import tmds_rx_pkg::*;
#(
  parameter int LOCK_TOKENS  = 16,
  parameter int SEARCH_WORDS = 4096,
  parameter int SLIP_SETTLE  = 8,
  parameter int LOSS_WORDS   = 8192
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       token,
  input  logic       relock,
  output logic       bitslip,
  output logic       locked,
  output logic       lock_next
`ifdef TMDS_RX_SLIP_COUNT_EN
  ,
  output logic [7:0] slip_count,
  output logic [7:0] loss_count
`endif
);

  localparam int RUN_W    = $clog2(LOCK_TOKENS + 1);
  localparam int WORD_W   = $clog2(SEARCH_WORDS + 1);
  localparam int SETTLE_W = $clog2(SLIP_SETTLE + 1);
  localparam int LOSS_W   = $clog2(LOSS_WORDS + 1);

  localparam logic [1:0] ST_SEARCH = SEARCH;
  localparam logic [1:0] ST_SLIP   = SLIP;
  localparam logic [1:0] ST_WAIT   = WAIT;
  localparam logic [1:0] ST_LOCKED = LOCKED;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [RUN_W-1:0]    run_cnt;
  logic [WORD_W-1:0]   word_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [LOSS_W-1:0]   loss_cnt;

  logic lock_hit;
  logic search_done;
  logic settle_done;
  logic loss_done;

  assign lock_hit    = token && (run_cnt == RUN_W'(LOCK_TOKENS - 1));
  assign search_done = (word_cnt == WORD_W'(SEARCH_WORDS - 1));
  assign settle_done = (settle_cnt == SETTLE_W'(SLIP_SETTLE - 1));
  assign loss_done   = (loss_cnt == LOSS_W'(LOSS_WORDS - 1));

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (relock) begin
      state_next = ST_SEARCH;
    end else begin
      case (state)
        ST_SEARCH: begin
          // A completed token run wins over an expiring search window.
          if (lock_hit)         state_next = ST_LOCKED;
          else if (search_done) state_next = ST_SLIP;
        end
        ST_SLIP:   state_next = ST_WAIT;
        ST_WAIT:   if (settle_done) state_next = ST_SEARCH;
        ST_LOCKED: if (!token && loss_done) state_next = ST_SEARCH;
        default:   state_next = ST_SEARCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_SEARCH;
      run_cnt    <= '0;
      word_cnt   <= '0;
      settle_cnt <= '0;
      loss_cnt   <= '0;
    end else begin
      state <= state_next;

      if (!relock && state == ST_SEARCH && state_next == ST_SEARCH) begin
        word_cnt <= word_cnt + WORD_W'(1);
        run_cnt  <= token ? run_cnt + RUN_W'(1) : '0;
      end else begin
        word_cnt <= '0;
        run_cnt  <= '0;
      end

      if (!relock && state == ST_WAIT) settle_cnt <= settle_cnt + SETTLE_W'(1);
      else                             settle_cnt <= '0;

      if (!relock && state == ST_LOCKED && !token) loss_cnt <= loss_cnt + LOSS_W'(1);
      else                                         loss_cnt <= '0;
    end
  end

  assign bitslip   = (state == ST_SLIP);
  assign locked    = (state == ST_LOCKED);
  assign lock_next = (state_next == ST_LOCKED);

`ifdef TMDS_RX_SLIP_COUNT_EN
  // Diagnostic counters survive relock; only reset clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slip_count <= '0;
      loss_count <= '0;
    end else begin
      if (state == ST_SLIP && slip_count != 8'hFF) slip_count <= slip_count + 8'd1;
      if (state == ST_LOCKED && state_next == ST_SEARCH && loss_count != 8'hFF)
        loss_count <= loss_count + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive channel after the 1:10 deserializer: word alignment via
// bitslip plus a two-stage decode pipeline. Optional TMDS_RX_SLIP_COUNT_EN.
module tmds_rx_channel
  import tmds_rx_pkg::*;
#(
  parameter int LOCK_TOKENS  = 16,
  parameter int SEARCH_WORDS = 4096,
  parameter int SLIP_SETTLE  = 8,
  parameter int LOSS_WORDS   = 8192
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [9:0] din,
  input  logic       relock,
  output logic       bitslip,
  output logic       locked,
  output logic       video_de,
  output logic [1:0] video_c,
  output logic [7:0] video_data
`ifdef TMDS_RX_SLIP_COUNT_EN
  ,
  output logic [7:0] slip_count,
  output logic [7:0] loss_count
`endif
);

  logic [9:0] din_q;
  logic       token_q;
  logic       lock_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) din_q <= '0;
    else          din_q <= din;
  end

  assign token_q = is_ctrl_token(din_q);

  tmds_rx_align_fsm #(
    .LOCK_TOKENS  (LOCK_TOKENS),
    .SEARCH_WORDS (SEARCH_WORDS),
    .SLIP_SETTLE  (SLIP_SETTLE),
    .LOSS_WORDS   (LOSS_WORDS)
  ) u_align (
    .clock      (clock),
    .reset_n    (reset_n),
    .token      (token_q),
    .relock     (relock),
    .bitslip    (bitslip),
    .locked     (locked),
    .lock_next  (lock_next)
`ifdef TMDS_RX_SLIP_COUNT_EN
    ,
    .slip_count (slip_count),
    .loss_count (loss_count)
`endif
  );

  // Gating on the FSM's next state keeps the video outputs in step with locked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      video_de   <= 1'b0;
      video_c    <= 2'b00;
      video_data <= 8'h00;
    end else if (!lock_next) begin
      video_de   <= 1'b0;
      video_c    <= 2'b00;
      video_data <= 8'h00;
    end else if (token_q) begin
      video_de   <= 1'b0;
      video_c    <= ctrl_token_value(din_q);
      video_data <= 8'h00;
    end else begin
      video_de   <= 1'b1;
      video_data <= tmds_decode_word(din_q);
    end
  end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Self-checking bench for tmds_rx_channel: random TMDS-encoded traffic is
// checked against the original bytes; alignment timing is checked in closed form.
module tb_tmds_rx_channel;

  localparam int LOCK_TOKENS  = 16;
  localparam int SEARCH_WORDS = 4096;
  localparam int SLIP_SETTLE  = 8;
  localparam int LOSS_WORDS   = 8192;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  typedef struct packed {
    logic       de;
    logic [1:0] c;
    logic [7:0] data;
  } vid_t;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       relock  = 1'b0;
  logic [9:0] din     = '0;
  logic       bitslip;
  logic       locked;
  logic       video_de;
  logic [1:0] video_c;
  logic [7:0] video_data;
`ifdef TMDS_RX_SLIP_COUNT_EN
  logic [7:0] slip_count;
  logic [7:0] loss_count;
`endif

  int checks = 0;
  int errors = 0;

  vid_t prev_e;
  logic [1:0] exp_c;

  tmds_rx_channel #(
    .LOCK_TOKENS  (LOCK_TOKENS),
    .SEARCH_WORDS (SEARCH_WORDS),
    .SLIP_SETTLE  (SLIP_SETTLE),
    .LOSS_WORDS   (LOSS_WORDS)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .din        (din),
    .relock     (relock),
    .bitslip    (bitslip),
    .locked     (locked),
    .video_de   (video_de),
    .video_c    (video_c),
    .video_data (video_data)
`ifdef TMDS_RX_SLIP_COUNT_EN
    ,
    .slip_count (slip_count),
    .loss_count (loss_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter-side TMDS encoding; inv chooses the DC-balance inversion freely.
  function automatic logic [9:0] tmds_encode(input logic [7:0] b, input logic inv);
    logic [8:0] qm;
    int         n1;
    logic       use_xnor;
    n1       = $countones(b);
    use_xnor = (n1 > 4) || (n1 == 4 && !b[0]);
    qm[0]    = b[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    qm[8] = ~use_xnor;
    return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm};
  endfunction

  function automatic logic [9:0] token_word(input logic [1:0] c);
    case (c)
      2'b00:   return T00;
      2'b01:   return T01;
      2'b10:   return T10;
      default: return T11;
    endcase
  endfunction

  // Deserializer view of a repeating word seen 'o' bits late on the wire.
  function automatic logic [9:0] rotate_word(input logic [9:0] w, input int o);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = w[(i + o) % 10];
    return r;
  endfunction

  task automatic tick(input logic [9:0] w);
    din = w;
    @(posedge clock);
    #1;
  endtask

  // Drives one word and checks the outputs belonging to the word before it.
  task automatic stream_word(input string tag, input logic [9:0] w, input vid_t e);
    tick(w);
    check({tag, "_de"},   video_de,   prev_e.de);
    check({tag, "_c"},    video_c,    prev_e.c);
    check({tag, "_data"}, video_data, prev_e.data);
    prev_e = e;
  endtask

  task automatic send_token(input string tag, input logic [1:0] c);
    exp_c = c;
    stream_word(tag, token_word(c), '{de: 1'b0, c: c, data: 8'h00});
  endtask

  task automatic send_data(input string tag, input logic [9:0] w, input logic [7:0] b);
    stream_word(tag, w, '{de: 1'b1, c: exp_c, data: b});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_locked"}, locked,     1'b0);
    check({tag, "_de"},     video_de,   1'b0);
    check({tag, "_c"},      video_c,    2'b00);
    check({tag, "_data"},   video_data, 8'h00);
  endtask

  initial begin
    int first_lock;
    int pulses;
    int last_pulse;
    int offset;
    int n;
    int mark;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_bitslip", bitslip, 1'b0);
    check_idle("rst");
    reset_n = 1'b1;

    // 1: aligned token stream
    first_lock = -1;
    pulses     = 0;
    for (int i = 1; i <= 280; i++) begin
      tick(T00);
      if (bitslip) pulses++;
      if (locked && first_lock < 0) first_lock = i;
    end
    check("t1_lock_tick", first_lock, LOCK_TOKENS + 1);
    check("t1_slips", pulses, 0);
    check("t1_locked", locked, 1'b1);
    check("t1_de", video_de, 1'b0);
    check("t1_c", video_c, 2'b00);

    // 3/4: directed decode and token cases, then random traffic
    prev_e = '{de: 1'b0, c: 2'b00, data: 8'h00};
    exp_c  = 2'b00;
    send_data("t3_w0", 10'b0100000000, 8'h00);
    send_data("t3_w1", 10'b1011111111, 8'hFE);
    send_data("t3_w2", 10'b0011111111, 8'hFF);
    send_token("t4_hs", 2'b01);
    send_data("t4_d", tmds_encode(8'hA5, 1'b0), 8'hA5);
    send_token("t4_c11", 2'b11);
    send_data("t4_d2", tmds_encode(8'h3C, 1'b1), 8'h3C);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) send_token("rnd_tok", 2'($urandom_range(0, 3)));
      else send_data("rnd_dat", tmds_encode(b, 1'($urandom_range(0, 1))), b);
    end

    // 5: loss of lock after LOSS_WORDS data words
    send_token("t5_tok", 2'b10);
    for (int i = 0; i < LOSS_WORDS; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      send_data("t5_dat", tmds_encode(b, 1'($urandom_range(0, 1))), b);
    end
    check("t5_still_locked", locked, 1'b1);
    tick(T00);
    check_idle("t5_lost");
`ifdef TMDS_RX_SLIP_COUNT_EN
    check("t5_loss_count", loss_count, 8'd1);
    check("t5_slip_count", slip_count, 8'd0);
`endif

    // 2: stream offset by 3 bits; each bitslip moves the window one bit
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n    = 1'b1;
    offset     = 3;
    pulses     = 0;
    last_pulse = 0;
    first_lock = -1;
    for (int i = 1; i <= 40000; i++) begin
      tick(rotate_word(T00, offset));
      if (bitslip) begin
        pulses++;
        if (pulses == 1) check("t2_first_slip", i, SEARCH_WORDS);
        else check("t2_slip_period", i - last_pulse, SEARCH_WORDS + 1 + SLIP_SETTLE);
        last_pulse = i;
        offset     = (offset + 1) % 10;
      end
      if (locked) begin
        first_lock = i;
        break;
      end
    end
    check("t2_locked", locked, 1'b1);
    check("t2_slips", pulses, 7);
    // pulse cycle, settle window, then a full token run
    check("t2_lock_delay", first_lock - last_pulse, 1 + SLIP_SETTLE + LOCK_TOKENS);
    for (int i = 0; i < 50; i++) begin
      tick(T00);
      if (bitslip) pulses++;
    end
    check("t2_no_extra_slip", pulses, 7);
    check("t2_hold_lock", locked, 1'b1);
`ifdef TMDS_RX_SLIP_COUNT_EN
    check("t2_slip_count", slip_count, 8'd7);
    check("t2_loss_count", loss_count, 8'd0);
`endif

    // 6: relock from LOCKED, during WAIT, and on the last search word
    relock = 1'b1;
    tick(T00);
    relock = 1'b0;
    check_idle("t6_relock_locked");
    n = 0;
    for (int i = 1; i <= SEARCH_WORDS + 100; i++) begin
      tick(10'b0100000000);
      if (bitslip) begin
        n = i;
        break;
      end
    end
    check("t6_search_len", n, SEARCH_WORDS);
    tick(10'b0100000000);
    relock = 1'b1;
    tick(10'b0100000000);
    relock = 1'b0;
    check("t6_wait_relock_slip", bitslip, 1'b0);
    check_idle("t6_wait_relock");
    n = 0;
    for (int i = 1; i <= SEARCH_WORDS + 100; i++) begin
      tick(10'b0100000000);
      if (bitslip) begin
        n = i;
        break;
      end
    end
    check("t6_after_wait_relock", n, SEARCH_WORDS);

    relock = 1'b1;
    tick(10'b0100000000);
    relock = 1'b0;
    pulses = 0;
    for (int i = 1; i < SEARCH_WORDS; i++) begin
      tick(10'b0100000000);
      if (bitslip) pulses++;
    end
    relock = 1'b1;
    tick(10'b0100000000);
    relock = 1'b0;
    if (bitslip) pulses++;
    check("t6_edge_relock_slips", pulses, 0);
    mark = 0;
    for (int i = 1; i <= SEARCH_WORDS + 100; i++) begin
      tick(10'b0100000000);
      if (bitslip) begin
        mark = i;
        break;
      end
    end
    check("t6_after_edge_relock", mark, SEARCH_WORDS);

    // Re-lock, show a data word, then reset asynchronously mid-cycle
    for (int i = 0; i < 100 && !locked; i++) tick(T00);
    check("t6_relocked", locked, 1'b1);
    tick(10'b0011111111);
    tick(T00);
    check("t6_pre_de", video_de, 1'b1);
    check("t6_pre_data", video_data, 8'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_bitslip", bitslip, 1'b0);
    check_idle("t6_async_rst");
`ifdef TMDS_RX_SLIP_COUNT_EN
    check("t6_rst_slip_count", slip_count, 8'd0);
    check("t6_rst_loss_count", loss_count, 8'd0);
`endif
    #20;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
